// File: rtl/bzmusic_seq.sv
// Buzzer music sequencer: fetches tune/beat entries from a latency-configurable ROM and plays square waves.
// Optional macro BZMUSIC_SEQ_DUTY_EN adds a duty_sh port selecting 50/25/12.5/6.25% duty.
module bzmusic_seq #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int ROM_LAT = 2,
    parameter int TICK_W  = 20
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic              pause,
    input  logic              loop_en,
    input  logic [TICK_W-1:0] tick_div,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_rd,
    input  logic [DATA_W-1:0] rom_data,
    output logic              busy,
    output logic              done,
    output logic              pwm_out
`ifdef BZMUSIC_SEQ_DUTY_EN
    ,
    input  logic [1:0]        duty_sh
`endif
);

    localparam int VAL_W = DATA_W - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_PLAY
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   addr;
    logic [VAL_W-1:0]    tune;
    logic [VAL_W-1:0]    beat_cnt;
    logic [VAL_W-1:0]    phase;
    logic [TICK_W-1:0]   tick_cnt;
    logic [2:0]          wait_cnt;

    logic [TICK_W-1:0]   tick_last;
    logic [VAL_W-1:0]    thr;
    logic [VAL_W-1:0]    phase_inc;
    logic [VAL_W-1:0]    phase_nxt;
    logic                is_tune;
    logic [VAL_W-1:0]    value;

    always_comb begin
        tick_last = (tick_div == '0) ? '0 : tick_div - TICK_W'(1);
`ifdef BZMUSIC_SEQ_DUTY_EN
        thr       = tune >> (3'd1 + {1'b0, duty_sh});
`else
        thr       = tune >> 1;
`endif
        // phase < tune always holds, so the increment cannot overflow
        phase_inc = phase + VAL_W'(1);
        phase_nxt = (phase_inc >= tune) ? '0 : phase_inc;
        is_tune   = rom_data[DATA_W-1];
        value     = rom_data[DATA_W-2:0];
    end

    assign rom_addr = addr;
    assign rom_rd   = (state == S_FETCH);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= S_IDLE;
            addr     <= '0;
            tune     <= '0;
            beat_cnt <= '0;
            phase    <= '0;
            tick_cnt <= '0;
            wait_cnt <= '0;
            pwm_out  <= 1'b0;
            done     <= 1'b0;
        end else if (!en) begin
            state    <= S_IDLE;
            addr     <= '0;
            tune     <= '0;
            beat_cnt <= '0;
            phase    <= '0;
            tick_cnt <= '0;
            wait_cnt <= '0;
            pwm_out  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    addr  <= '0;
                    tune  <= '0;
                    state <= S_FETCH;
                end
                S_FETCH: begin
                    wait_cnt <= '0;
                    state    <= (ROM_LAT == 1) ? S_DECODE : S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == 3'(ROM_LAT - 2))
                        state <= S_DECODE;
                    else
                        wait_cnt <= wait_cnt + 3'd1;
                end
                S_DECODE: begin
                    if (is_tune) begin
                        tune  <= value;
                        addr  <= addr + ADDR_W'(1);
                        state <= S_FETCH;
                    end else if (value != '0) begin
                        beat_cnt <= value;
                        tick_cnt <= '0;
                        phase    <= '0;
                        // first PLAY cycle shows phase 0
                        pwm_out  <= (thr != '0);
                        addr     <= addr + ADDR_W'(1);
                        state    <= S_PLAY;
                    end else if (loop_en) begin
                        addr  <= '0;
                        state <= S_FETCH;
                    end else begin
                        done  <= 1'b1;
                        addr  <= '0;
                        tune  <= '0;
                        state <= S_IDLE;
                    end
                end
                S_PLAY: begin
                    if (pause) begin
                        pwm_out <= 1'b0;
                    end else begin
                        phase   <= phase_nxt;
                        pwm_out <= (phase_nxt < thr);
                        if (tick_cnt >= tick_last) begin
                            tick_cnt <= '0;
                            beat_cnt <= beat_cnt - VAL_W'(1);
                            if (beat_cnt <= VAL_W'(1)) begin
                                pwm_out <= 1'b0;
                                state   <= S_FETCH;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TICK_W'(1);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bzmusic_seq.sv
// Directed self-checking bench for bzmusic_seq: per-cycle capture of outputs compared against hand-derived bit patterns.
module tb_bzmusic_seq;

    logic        clk;
    logic        rstn;
    logic        en, pause, loop_en;
    logic [19:0] tick_div;
    logic [7:0]  rom_addr;
    logic        rom_rd;
    logic [15:0] rom_data;
    logic        busy, done, pwm_out;

    logic        en2;
    logic [19:0] tick_div2;
    logic [1:0]  rom_addr2;
    logic        rom_rd2;
    logic [15:0] rom_data2;
    logic        busy2, done2, pwm2;
`ifdef BZMUSIC_SEQ_DUTY_EN
    logic [1:0]  duty_sh = 2'd0;
`endif

    logic [15:0] mem [256];
    logic [15:0] mem2 [4];
    logic [15:0] pipe0, pipe1;

    int checks = 0;
    int errors = 0;

    logic [63:0]  rd_v, pwm_v, done_v, busy_v;
    logic [127:0] aseq;
    int           addr_arr [64];
    logic [63:0]  e_rd, e_pwm;
    int           c;

    bzmusic_seq #(.ADDR_W(8), .DATA_W(16), .ROM_LAT(2), .TICK_W(20)) dut (
        .clk(clk), .rstn(rstn), .en(en), .pause(pause), .loop_en(loop_en),
        .tick_div(tick_div), .rom_addr(rom_addr), .rom_rd(rom_rd), .rom_data(rom_data),
        .busy(busy), .done(done), .pwm_out(pwm_out)
`ifdef BZMUSIC_SEQ_DUTY_EN
        , .duty_sh(duty_sh)
`endif
    );

    bzmusic_seq #(.ADDR_W(2), .DATA_W(16), .ROM_LAT(1), .TICK_W(20)) dut2 (
        .clk(clk), .rstn(rstn), .en(en2), .pause(1'b0), .loop_en(1'b0),
        .tick_div(tick_div2), .rom_addr(rom_addr2), .rom_rd(rom_rd2), .rom_data(rom_data2),
        .busy(busy2), .done(done2), .pwm_out(pwm2)
`ifdef BZMUSIC_SEQ_DUTY_EN
        , .duty_sh(duty_sh)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM models: two-cycle latency for dut, one-cycle for dut2
    always @(posedge clk) begin
        pipe0     <= mem[rom_addr];
        pipe1     <= pipe0;
        rom_data2 <= mem2[rom_addr2];
    end
    assign rom_data = pipe1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    // Starts at a negedge with en raised; cycle 0 is the first cycle after the next posedge.
    task automatic capture(input int n, input int ps, input int pe, input int en_off);
        rd_v = '0; pwm_v = '0; done_v = '0; busy_v = '0; aseq = '0;
        en = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rd_v[i]   = rom_rd;
            pwm_v[i]  = pwm_out;
            done_v[i] = done;
            busy_v[i] = busy;
            addr_arr[i] = int'(rom_addr);
            if (rom_rd) aseq = {aseq[119:0], rom_addr};
            pause = (i >= ps && i < pe);
            en    = (i != en_off);
        end
        en    = 1'b0;
        pause = 1'b0;
    endtask

    task automatic settle();
        en = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; pause = 1'b0; loop_en = 1'b0; tick_div = 20'd4;
        en2 = 1'b0; tick_div2 = 20'd0;
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        for (int i = 0; i < 4; i++) mem2[i] = 16'h0001;
        mem[0] = 16'h8008; mem[1] = 16'h0003; mem[2] = 16'h0000;

        repeat (2) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_rd", rom_rd, 1'b0);
        check("rst_pwm", pwm_out, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_addr", rom_addr, 8'h00);
        check("rst_dut2", {busy2, rom_rd2, done2, pwm2, rom_addr2}, 6'd0);
        rstn = 1'b1;
        @(negedge clk);

        // basic tune + 3-beat tone + end
        capture(22, -1, -1, -1);
        check("t1_rd", rd_v, 64'h0000_0000_0004_0009);
        check("t1_addrs", aseq, 128'h000102);
        check("t1_pwm", pwm_v, 64'h0000_0000_0003_C3C0);
        check("t1_done", done_v, 64'h0000_0000_0020_0000);
        check("t1_busy", busy_v, 64'h0000_0000_001F_FFFF);
        check("t1_addr_play", addr_arr[10], 2);
        check("t1_addr_end", addr_arr[21], 0);
        @(negedge clk);
        check("t1_idle_after", {busy, done, rom_rd}, 3'b000);
        settle();

        // loop mode: 21-cycle period repeats, no done
        loop_en = 1'b1;
        capture(64, -1, -1, -1);
        e_rd = '0; e_pwm = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 21; j++) begin
                c = 21 * k + j;
                if (c < 64) begin
                    e_rd[c]  = (j == 0 || j == 3 || j == 18);
                    e_pwm[c] = (j >= 6 && j <= 9) || (j >= 14 && j <= 17);
                end
            end
        end
        check("t2_rd", rd_v, e_rd);
        check("t2_pwm", pwm_v, e_pwm);
        check("t2_done", done_v, 64'h0);
        check("t2_busy", busy_v, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t2_addrs", aseq, 128'h0001_0200_0102_0001_0200);
        loop_en = 1'b0;
        settle();

        // rest with tick_div=0 treated as 1
        mem[0] = 16'h0002; mem[1] = 16'h0000;
        tick_div = 20'd0;
        capture(9, -1, -1, -1);
        check("t3_rd", rd_v, 64'h21);
        check("t3_pwm", pwm_v, 64'h0);
        check("t3_done", done_v, 64'h100);
        check("t3_busy", busy_v, 64'hFF);
        settle();

        // pause for 10 cycles inside the beat
        mem[0] = 16'h8008; mem[1] = 16'h0003; mem[2] = 16'h0000;
        tick_div = 20'd4;
        capture(32, 6, 16, -1);
        check("t4_rd", rd_v, 64'h1000_0009);
        check("t4_pwm", pwm_v, 64'h0F0E_0040);
        check("t4_done", done_v, 64'h8000_0000);
        check("t4_busy", busy_v, 64'h7FFF_FFFF);
        settle();

        // en dropped mid-PLAY for one cycle, then restarted from address 0
        capture(34, -1, -1, 10);
        check("t5_rd", rd_v, 64'h4000_9009);
        check("t5_addrs", aseq, 128'h00_0100_0102);
        check("t5_pwm", pwm_v, 64'h3C3C_03C0);
        check("t5_busy", busy_v, 64'h1_FFFF_F7FF);
        check("t5_done", done_v, 64'h2_0000_0000);
        check("t5_addr_before", addr_arr[10], 2);
        check("t5_addr_off", addr_arr[11], 0);
        settle();

        // ADDR_W=2, ROM_LAT=1: address wraps 3 -> 0 with a steady 3-cycle cadence
        rd_v = '0; busy_v = '0; pwm_v = '0; aseq = '0;
        en2 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            rd_v[i]   = rom_rd2;
            busy_v[i] = busy2;
            pwm_v[i]  = pwm2;
            if (rom_rd2) aseq = {aseq[119:0], 6'd0, rom_addr2};
        end
        en2 = 1'b0;
        check("t6_rd", rd_v, 64'h9249);
        check("t6_addrs", aseq, 128'h0001_0203_0001);
        check("t6_busy", busy_v, 64'hFFFF);
        check("t6_pwm", pwm_v, 64'h0);
        @(negedge clk);
        check("t6_stop", {busy2, rom_addr2}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
